// File: rtl/alu_issue_queue_if.sv
// Bundle between decode, register file, writeback and the ALU issue queue.
// master is the surrounding pipeline; slave is the queue itself.
interface alu_issue_queue_if;
    logic        dis_valid;
    logic        dis_ready;
    logic [3:0]  dis_aluop;
    logic [4:0]  dis_rs1;
    logic [4:0]  dis_rs2;
    logic [4:0]  dis_rd;
    logic [31:0] dis_imm;
    logic        dis_use_imm;
    logic        dis_wen;

    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;

    logic        wb_valid;
    logic [4:0]  wb_rd;

    logic        iss_a0_stall;
    logic        iss_a0_valid;
    logic [31:0] iss_a0_rega;
    logic [31:0] iss_a0_regb;
    logic [3:0]  iss_a0_aluop;
    logic [4:0]  iss_a0_rd;
    logic        iss_a0_wen;

    modport master (
        output dis_valid, dis_aluop, dis_rs1, dis_rs2, dis_rd,
        output dis_imm, dis_use_imm, dis_wen,
        input  dis_ready,
        input  rf_rs1, rf_rs2,
        output rf_data1, rf_data2,
        output wb_valid, wb_rd,
        output iss_a0_stall,
        input  iss_a0_valid, iss_a0_rega, iss_a0_regb,
        input  iss_a0_aluop, iss_a0_rd, iss_a0_wen
    );

    modport slave (
        input  dis_valid, dis_aluop, dis_rs1, dis_rs2, dis_rd,
        input  dis_imm, dis_use_imm, dis_wen,
        output dis_ready,
        output rf_rs1, rf_rs2,
        input  rf_data1, rf_data2,
        input  wb_valid, wb_rd,
        input  iss_a0_stall,
        output iss_a0_valid, iss_a0_rega, iss_a0_regb,
        output iss_a0_aluop, iss_a0_rd, iss_a0_wen
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Four-entry in-order ALU issue queue with a register busy scoreboard
// and a single registered issue slot feeding ALU 0.
module alu_issue_queue (
    input  logic              clock,
    input  logic              reset,
    alu_issue_queue_if.slave  bus
);

    typedef struct packed {
        logic [3:0]  aluop;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        wen;
    } entry_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rega;
        logic [31:0] regb;
        logic [3:0]  aluop;
        logic [4:0]  rd;
        logic        wen;
    } iss_t;

    entry_t      mem_q [4];
    entry_t      mem_d [4];
    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] busy_q, busy_d;
    iss_t        iss_q, iss_d;

    entry_t      head;
    entry_t      dis_entry;
    logic        dis_ready;
    logic        dis_fire;
    logic        src_ok;
    logic        iss_fire;

    // Ready looks only at the registered count, never at a same-cycle issue.
    assign dis_ready     = reset && (count_q < 3'd4);
    assign bus.dis_ready = dis_ready;

    always_comb begin
        head     = mem_q[head_q];
        dis_fire = bus.dis_valid && dis_ready;
        src_ok   = !busy_q[head.rs1] &&
                   (head.use_imm || !busy_q[head.rs2]);
        iss_fire = (count_q != 3'd0) && !bus.iss_a0_stall && src_ok;

        dis_entry.aluop   = bus.dis_aluop;
        dis_entry.rs1     = bus.dis_rs1;
        dis_entry.rs2     = bus.dis_rs2;
        dis_entry.rd      = bus.dis_rd;
        dis_entry.imm     = bus.dis_imm;
        dis_entry.use_imm = bus.dis_use_imm;
        dis_entry.wen     = bus.dis_wen;
    end

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + {2'b00, dis_fire} - {2'b00, iss_fire};

        if (dis_fire) begin
            mem_d[tail_q] = dis_entry;
            tail_d        = tail_q + 2'd1;
        end
        if (iss_fire) begin
            head_d = head_q + 2'd1;
        end
    end

    // Clear first so an issue-time set of the same rd wins.
    always_comb begin
        busy_d = busy_q;
        if (bus.wb_valid) begin
            busy_d[bus.wb_rd] = 1'b0;
        end
        if (iss_fire && head.wen && (head.rd != 5'd0)) begin
            busy_d[head.rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        iss_d = iss_q;
        if (iss_fire) begin
            iss_d.valid = 1'b1;
            iss_d.rega  = bus.rf_data1;
            iss_d.regb  = head.use_imm ? head.imm : bus.rf_data2;
            iss_d.aluop = head.aluop;
            iss_d.rd    = head.rd;
            iss_d.wen   = head.wen;
        end else if (!bus.iss_a0_stall) begin
            iss_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            count_q <= 3'd0;
            busy_q  <= '0;
            iss_q   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= mem_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            iss_q   <= iss_d;
        end
    end

    assign bus.rf_rs1       = head.rs1;
    assign bus.rf_rs2       = head.rs2;
    assign bus.iss_a0_valid = iss_q.valid;
    assign bus.iss_a0_rega  = iss_q.rega;
    assign bus.iss_a0_regb  = iss_q.regb;
    assign bus.iss_a0_aluop = iss_q.aluop;
    assign bus.iss_a0_rd    = iss_q.rd;
    assign bus.iss_a0_wen   = iss_q.wen;

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 One clock; reset is synchronous and active-low; ports are named clock and reset.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-low reset.
REQ-004 dis_valid  in  1  decode offers one instruction this cycle.
REQ-005 dis_ready  out  1  queue can accept; transfer when dis_valid and dis_ready are both 1 at a rising edge.
REQ-006 dis_aluop  in  4  ALU operation code, passed through unchanged.
REQ-007 dis_rs1, dis_rs2, dis_rd  in  5 each  source and destination register ids.
REQ-008 dis_imm  in  32  sign-extended immediate.
REQ-009 dis_use_imm  in  1  operand B is dis_imm instead of rs2 data.
REQ-010 dis_wen  in  1  instruction writes rd.
REQ-011 rf_rs1, rf_rs2  out  5 each  register-file read addresses, equal to the head entry's rs1/rs2.
REQ-012 rf_data1, rf_data2  in  32 each  combinational register-file read data.
REQ-013 wb_valid  in  1 and wb_rd  in  5  writeback of rd this cycle; the register file writes on the same edge.
REQ-014 iss_a0_stall  in  1  ALU cannot take a new instruction.
REQ-015 iss_a0_valid  out  1  issue register holds a valid instruction.
REQ-016 iss_a0_rega, iss_a0_regb  out  32 each  operand A and operand B.
REQ-017 iss_a0_aluop  out  4; iss_a0_rd  out  5; iss_a0_wen  out  1  registered copies from the issued entry.

Function
REQ-018 Storage: 4-entry circular FIFO with 2-bit head/tail pointers wrapping 3->0 and a 3-bit count of 0..4.
REQ-019 dis_ready SHALL be 1 only when count<4 and reset=1; it is registered-count based, with no same-cycle pass-through when full, even if an issue occurs.
REQ-020 Scoreboard: 32 busy bits; x0 is never busy; a set request for rd=0 is ignored.
REQ-021 Head may issue when count>0, iss_a0_stall=0, rs1 is not busy, and rs2 is not busy or use_imm=1.
REQ-022 On issue at an edge: the issue register loads rega=rf_data1; regb=use_imm ? imm : rf_data2; aluop, rd, wen are copied; iss_a0_valid=1; head advances; count decrements, unless a dispatch occurs on the same edge.
REQ-023 On issue with wen=1 and rd!=0, busy[rd] SHALL be set on the same edge.
REQ-024 wb_valid=1 clears busy[wb_rd] at the edge; if set and clear target the same rd on the same edge, set wins.
REQ-025 There is no writeback bypass: a head waiting on rd issues no earlier than the edge after the wb edge.
REQ-026 Without issue and with iss_a0_stall=0, iss_a0_valid SHALL drop to 0 at the next edge while the data outputs hold; each issued instruction is valid for exactly one cycle.
REQ-027 With iss_a0_stall=1, the issue register holds all fields including valid, and no new issue occurs.
REQ-028 Simultaneous dispatch and issue SHALL leave count unchanged and move both pointers.
REQ-029 Latency: dispatch at edge N gives iss_a0_valid=1 after edge N+1 at the earliest; there is no dispatch-to-issue bypass when empty.
REQ-030 Issue is strictly in order: a blocked head blocks all younger entries.

Reset
REQ-031 At a rising edge with reset=0: count=0, head=tail=0, all busy=0, iss_a0_valid=0, and iss_a0_rega/regb/aluop/rd/wen=0.
REQ-032 Reset mid-operation discards all queued entries and the issue register contents; dispatch attempted in that cycle is dropped.
REQ-033 dis_ready=0 while reset=0; it becomes 1 in the first cycle after reset is released.

Verification
REQ-034 Setup: x5=0, reset low for 1 edge, then dispatch addi x10,x5,7 -> after edge N+1, iss_a0_valid=1, rega=0, regb=7, rd=10, wen=1.
REQ-035 Dependency: dispatch addi x11,x10,8 right after the previous instruction, with wb of x10=7 two cycles after issue -> no issue while busy[10]=1; then rega=7, regb=8, rd=11.
REQ-036 Two sources: add x12,x10,x11 with x10 clear and x11 busy -> issues only the edge after wb x11=15, with rega=7 and regb=15.
REQ-037 Full: 5 back-to-back dispatches with head blocked -> dis_ready=0 after the 4th accept; the 5th is held by decode; one issue then re-raises dis_ready.
REQ-038 Stall and conflict: assert iss_a0_stall for 3 cycles with an issued instruction -> outputs constant and valid=1 throughout; wb and issue set of the same rd on one edge -> busy stays 1.
REQ-039 Reset with 3 entries queued and x10 busy -> after the reset edge, count=0, iss_a0_valid=0, busy[10]=0, and a fresh dispatch issues with latency 2.
